// File: rtl/jtopl_wrbuf.sv
// CPU write buffer ahead of the OPL register map: the CPU bus is sampled once, writes are queued, then replayed as 1-clk strobes paced by cenop wait times.
// Latency: event edge k -> strobe k+2 when idle. There is no backpressure: a write arriving on a full FIFO is dropped and ovf sets.
module jtopl_wrbuf #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ADDR_WAIT = 8'd12,
  parameter logic [7:0] DATA_WAIT = 8'd84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       irq_n,
  output logic       write,
  output logic       wr_addr,
  output logic [7:0] wr_din,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_wait;
  logic          r_cs_n, r_wr_n, r_wr_n_l, r_addr;
  logic [7:0]    r_din;

  logic       w_event, w_pop, w_push;
  logic [8:0] w_head;

  // Edge detection runs on the sampled bus, which sets the two-edge event-to-strobe latency.
  assign w_event = !r_cs_n && !r_wr_n && r_wr_n_l;
  assign w_pop   = (r_count != '0) && (r_wait == 8'd0) && !write;
  assign w_push  = w_event && (!full || w_pop);
  assign w_head  = r_mem[r_rptr];

  assign full = (r_count == FULL_CNT);
  assign busy = (r_count != '0) || (r_wait != 8'd0) || write;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_addr, r_din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_wr_n_l <= 1'b1;
      r_addr   <= 1'b0;
      r_din    <= 8'd0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wait   <= 8'd0;
      write    <= 1'b0;
      wr_addr  <= 1'b0;
      wr_din   <= 8'd0;
      ovf      <= 1'b0;
      dout     <= 8'd0;
    end else begin
      r_cs_n   <= cs_n;
      r_wr_n   <= wr_n;
      r_wr_n_l <= r_wr_n;
      r_addr   <= addr;
      r_din    <= din;

      write <= w_pop;
      if (w_pop) begin
        wr_addr <= w_head[8];
        wr_din  <= w_head[7:0];
        r_rptr  <= r_rptr + AW'(1);
        r_wait  <= w_head[8] ? DATA_WAIT : ADDR_WAIT;
      end else if (cenop && (r_wait != 8'd0)) begin
        r_wait <= r_wait - 8'd1;
      end

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_event && !w_push) ovf <= 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      dout <= (!cs_n && !rd_n && !addr) ? {~irq_n, flag_A, flag_B, 4'd0, busy} : 8'd0;
    end
  end

endmodule

// File: tb/tb_jtopl_wrbuf.sv
// Bench for jtopl_wrbuf: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_jtopl_wrbuf;
  localparam int DEPTH = 4;
  localparam int AWAIT = 12;
  localparam int DWAIT = 84;

  logic       clk, rst, cenop, cs_n, wr_n, rd_n, addr;
  logic [7:0] din, dout, wr_din;
  logic       flag_A, flag_B, irq_n, write, wr_addr, busy, full, ovf;

  jtopl_wrbuf #(.DEPTH(DEPTH), .ADDR_WAIT(8'(AWAIT)), .DATA_WAIT(8'(DWAIT))) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .din(din), .dout(dout), .flag_A(flag_A), .flag_B(flag_B),
    .irq_n(irq_n), .write(write), .wr_addr(wr_addr), .wr_din(wr_din),
    .busy(busy), .full(full), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cenop: fixed 1-in-4 pattern or random
  bit cen_rand = 1'b0;
  initial begin
    int cnt;
    cnt   = 0;
    cenop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cen_rand) cenop = ($urandom_range(0, 2) == 0);
      else begin
        cnt   = (cnt + 1) % 4;
        cenop = (cnt == 0);
      end
    end
  end

  // Reference model: FIFO as a queue, wait time as an integer tick count
  typedef logic [8:0] ent_t;
  ent_t       mq[$];
  int         m_wait;
  bit         m_write, m_wa, m_ovf, model_ok = 1'b0;
  logic [7:0] m_wd, m_dout;
  bit         s_cs, s_wrn, s_wrnl, s_addr;
  logic [7:0] s_din;

  always @(posedge clk) begin
    bit   ev, pop, busy_pre;
    int   sz;
    ent_t head;
    if (rst) begin
      mq.delete();
      m_wait = 0; m_write = 0; m_wa = 0; m_wd = 8'd0; m_dout = 8'd0; m_ovf = 0;
      s_cs = 1; s_wrn = 1; s_wrnl = 1; s_addr = 0; s_din = 8'd0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      busy_pre = (mq.size() != 0) || (m_wait != 0) || m_write;
      m_dout = (!cs_n && !rd_n && !addr) ? {~irq_n, flag_A, flag_B, 4'd0, busy_pre} : 8'd0;
      ev  = !s_cs && !s_wrn && s_wrnl;
      sz  = mq.size();
      pop = (sz != 0) && (m_wait == 0) && !m_write;
      m_write = pop;
      if (pop) begin
        head   = mq.pop_front();
        m_wa   = head[8];
        m_wd   = head[7:0];
        m_wait = head[8] ? DWAIT : AWAIT;
      end else if (cenop && m_wait > 0) m_wait--;
      if (ev) begin
        if (sz < DEPTH || pop) mq.push_back({s_addr, s_din});
        else m_ovf = 1'b1;
      end
      s_wrnl = s_wrn; s_cs = cs_n; s_wrn = wr_n; s_addr = addr; s_din = din;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_write", write, m_write);
      chk("m_wr_addr", wr_addr, m_wa);
      chk("m_wr_din", wr_din, m_wd);
      chk("m_busy", busy, (mq.size() != 0) || (m_wait != 0) || m_write);
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_ovf", ovf, m_ovf);
      chk("m_dout", dout, m_dout);
    end
  end

  // Strobe capture
  ent_t cap[$];
  always @(negedge clk) if (write === 1'b1) cap.push_back({wr_addr, wr_din});

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input bit a, input logic [7:0] d);
    cs_n = 0; wr_n = 0; addr = a; din = d;
    tick(1);
    wr_n = 1; cs_n = 1;
    tick(1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    ent_t exp_e[$];
    int   n;
    rst = 1; cs_n = 1; wr_n = 1; rd_n = 1; addr = 0; din = 8'd0;
    flag_A = 0; flag_B = 0; irq_n = 1;
    tick(3);
    rst = 0;
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", dout, 0);
    chk("rst_wr_din", wr_din, 0);
    tick(2);

    // single write: latency and wait time
    cs_n = 0; wr_n = 0; addr = 0; din = 8'h20;
    tick(1);
    wr_n = 1; cs_n = 1;
    chk("lat_k", write, 0);
    tick(1);
    chk("lat_k1", write, 0);
    tick(1);
    chk("lat_k2", write, 1);
    chk("lat_addr", wr_addr, 0);
    chk("lat_din", wr_din, 8'h20);
    tick(1);
    chk("lat_k3", write, 0);
    chk("hold_din", wr_din, 8'h20);
    n = 1;
    while (busy !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("busy_fall_window", (n >= 45 && n <= 48), 1);

    // burst of four
    cap.delete();
    exp_e = '{9'h020, 9'h101, 9'h0A0, 9'h155};
    foreach (exp_e[i]) cpu_write(exp_e[i][8], exp_e[i][7:0]);
    wait_idle("burst_idle", 3000);
    chk("burst_count", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk("burst_order", cap[i], exp_e[i]);

    // six writes: last one dropped
    cap.delete();
    exp_e.delete();
    for (int i = 0; i < 6; i++) begin
      exp_e.push_back(ent_t'({1'($urandom_range(0, 1)), 8'($urandom)}));
      cpu_write(exp_e[i][8], exp_e[i][7:0]);
    end
    chk("ovf_set", ovf, 1);
    chk("full_set", full, 1);
    wait_idle("ovf_idle", 5000);
    chk("ovf_count", cap.size(), 5);
    for (int i = 0; i < 5 && i < cap.size(); i++) chk("ovf_order", cap[i], exp_e[i]);
    chk("ovf_sticky", ovf, 1);

    // long write strobe
    cap.delete();
    cs_n = 0; wr_n = 0; addr = 1; din = 8'h3C;
    tick(10);
    wr_n = 1; cs_n = 1;
    wait_idle("long_idle", 2000);
    chk("long_count", cap.size(), 1);
    if (cap.size() > 0) chk("long_data", cap[0], 9'h13C);

    // status read while busy
    cpu_write(0, 8'h11);
    flag_A = 1; flag_B = 0; irq_n = 0;
    cs_n = 0; rd_n = 0; addr = 0;
    tick(1);
    chk("read_status", dout, 8'hC1);
    addr = 1;
    tick(1);
    chk("read_addr1", dout, 8'h00);
    cs_n = 1; rd_n = 1; addr = 0; flag_A = 0; irq_n = 1;
    wait_idle("read_idle", 2000);

    // reset mid-wait with two entries queued
    cpu_write(1, 8'hA1);
    cpu_write(1, 8'hA2);
    cpu_write(1, 8'hA3);
    tick(2);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    tick(1);
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_write", write, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_full", full, 0);
    cap.delete();
    tick(100);
    chk("mid_rst_no_strobe", cap.size(), 0);

    // random traffic against the model
    cen_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cs_n   = ($urandom_range(0, 3) == 0);
      wr_n   = ($urandom_range(0, 11) != 0);
      rd_n   = $urandom_range(0, 1);
      addr   = $urandom_range(0, 1);
      din    = 8'($urandom);
      flag_A = $urandom_range(0, 1);
      flag_B = $urandom_range(0, 1);
      irq_n  = $urandom_range(0, 1);
      rst    = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 0; cs_n = 1; wr_n = 1; rd_n = 1;
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
